// File: rtl/sevenseg_scanner.sv
// Time-multiplexed scanner for a common-segment, DIGITS-wide 7-segment display.
// Each digit slot begins with an all-anodes-off guard window to avoid ghosting.
// A pending/display register pair means a new value only appears at a frame boundary.
// Optional feature macro: SEVENSEG_LZ_BLANK_EN (leading-zero suppression).
module sevenseg_scanner #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned PRESCALE = 1024,
  parameter int unsigned GUARD    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  blank,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done,
  output logic                  load_pending
);

  localparam int unsigned VW = 4 * DIGITS;
  localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [VW-1:0]     disp_q, disp_d;
  logic [DIGITS-1:0] disp_dp_q, disp_dp_d;
  logic [VW-1:0]     pend_q, pend_d;
  logic [DIGITS-1:0] pend_dp_q, pend_dp_d;
  logic              pend_valid_q, pend_valid_d;
  logic              frame_done_q, frame_done_d;
  logic              boundary;

  logic [3:0]        nib;
  logic              dp_sel;
  logic              dark;
`ifdef SEVENSEG_LZ_BLANK_EN
  logic [DIGITS-1:0] lz_dark;
  logic              zero_above;
`endif

  // Hex nibble to {a,b,c,d,e,f,g} segment pattern, 1 = lit.
  function automatic logic [6:0] font(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h7E;
      4'h1: s = 7'h30;
      4'h2: s = 7'h6D;
      4'h3: s = 7'h79;
      4'h4: s = 7'h33;
      4'h5: s = 7'h5B;
      4'h6: s = 7'h5F;
      4'h7: s = 7'h70;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h7B;
      4'hA: s = 7'h77;
      4'hB: s = 7'h1F;
      4'hC: s = 7'h4E;
      4'hD: s = 7'h3D;
      4'hE: s = 7'h4F;
      default: s = 7'h47;
    endcase
    return s;
  endfunction

  // Scan counters, frame pulse and the pending-to-display hand-over.
  always_comb begin
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    disp_d       = disp_q;
    disp_dp_d    = disp_dp_q;
    pend_d       = pend_q;
    pend_dp_d    = pend_dp_q;
    pend_valid_d = pend_valid_q;
    frame_done_d = 1'b0;

    boundary = !blank && (cnt_q == CW'(PRESCALE - 1)) && (idx_q == IW'(DIGITS - 1));

    if (blank) begin
      cnt_d = '0;
      idx_d = '0;
    end else if (cnt_q == CW'(PRESCALE - 1)) begin
      cnt_d = '0;
      idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
    end else begin
      cnt_d = cnt_q + CW'(1);
    end

    frame_done_d = boundary;

    // While blanked nothing is visible, so pending can move across every cycle.
    if ((blank || boundary) && pend_valid_q) begin
      disp_d       = pend_q;
      disp_dp_d    = pend_dp_q;
      pend_valid_d = 1'b0;
    end

    // A load landing on the boundary edge is newer than any pending value.
    if (load) begin
      pend_d    = value;
      pend_dp_d = dp_in;
      if (boundary) begin
        disp_d       = value;
        disp_dp_d    = dp_in;
        pend_valid_d = 1'b0;
      end else begin
        pend_valid_d = 1'b1;
      end
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      disp_q       <= '0;
      disp_dp_q    <= '0;
      pend_q       <= '0;
      pend_dp_q    <= '0;
      pend_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      disp_q       <= disp_d;
      disp_dp_q    <= disp_dp_d;
      pend_q       <= pend_d;
      pend_dp_q    <= pend_dp_d;
      pend_valid_q <= pend_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Display drive decoded from the registered scan position.
  always_comb begin
    seg    = '0;
    dp     = 1'b0;
    an     = '0;
    nib    = '0;
    dp_sel = 1'b0;
    dark   = 1'b0;
`ifdef SEVENSEG_LZ_BLANK_EN
    lz_dark    = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above && (disp_q[4*i +: 4] == 4'h0);
      lz_dark[i] = zero_above && (i != 0);
    end
`endif
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        nib    = disp_q[4*i +: 4];
        dp_sel = disp_dp_q[i];
`ifdef SEVENSEG_LZ_BLANK_EN
        dark   = lz_dark[i];
`endif
      end
    end
    if (!blank && (cnt_q >= CW'(GUARD))) begin
      an  = DIGITS'(1) << idx_q;
      seg = dark ? 7'h00 : font(nib);
      dp  = dp_sel;
    end
  end

  assign frame_done   = frame_done_q;
  assign load_pending = pend_valid_q;

endmodule

// File: tb/tb_sevenseg_scanner.sv
// Randomised and directed bench for sevenseg_scanner against a time-based reference model.
module tb_sevenseg_scanner;

  localparam int P  = 8;
  localparam int G  = 2;
  localparam int D  = 4;
  localparam int FR = P * D;

  logic        clk;
  logic        reset;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        blank;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;
  logic        load_pending;

  sevenseg_scanner #(.DIGITS(D), .PRESCALE(P), .GUARD(G)) dut (
    .clk          (clk),
    .reset        (reset),
    .load         (load),
    .value        (value),
    .dp_in        (dp_in),
    .blank        (blank),
    .seg          (seg),
    .dp           (dp),
    .an           (an),
    .frame_done   (frame_done),
    .load_pending (load_pending)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: time since scan start plus shown/pending values.
  int          m_t;
  logic [15:0] m_disp, m_pend;
  logic [3:0]  m_ddp, m_pdp;
  logic        m_pv, m_fd;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp;
  logic [6:0]  font_tab [16];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, got, exp, m_t);
    end
  endtask

  function automatic void model_reset();
    m_t = 0; m_disp = '0; m_pend = '0; m_ddp = '0; m_pdp = '0; m_pv = 1'b0; m_fd = 1'b0;
  endfunction

  function automatic void model_out();
    int dig;
    int ph;
    int n;
    dig = (m_t / P) % D;
    ph  = m_t % P;
    n   = int'((m_disp >> (4 * dig)) & 16'hF);
    e_an = '0; e_seg = '0; e_dp = 1'b0;
    if (!blank && ph >= G) begin
      e_an  = 4'(1 << dig);
      e_seg = font_tab[n];
      e_dp  = m_ddp[dig];
`ifdef SEVENSEG_LZ_BLANK_EN
      if (dig > 0 && (m_disp >> (4 * dig)) == 16'h0) e_seg = '0;
`endif
    end
  endfunction

  function automatic void model_update();
    logic bnd;
    bnd  = !blank && (m_t == FR - 1);
    m_fd = bnd;
    if (blank) begin
      if (m_pv) begin m_disp = m_pend; m_ddp = m_pdp; m_pv = 1'b0; end
      if (load) begin m_pend = value; m_pdp = dp_in; m_pv = 1'b1; end
      m_t = 0;
    end else begin
      if (load && bnd) begin
        m_disp = value; m_ddp = dp_in; m_pend = value; m_pdp = dp_in; m_pv = 1'b0;
      end else begin
        if (bnd && m_pv) begin m_disp = m_pend; m_ddp = m_pdp; m_pv = 1'b0; end
        if (load) begin m_pend = value; m_pdp = dp_in; m_pv = 1'b1; end
      end
      m_t = (m_t + 1) % FR;
    end
  endfunction

  // Apply inputs at the falling edge and compare all outputs with the model.
  task automatic drive(input logic l, input logic [15:0] v, input logic [3:0] d, input logic b);
    @(negedge clk);
    load = l; value = v; dp_in = d; blank = b;
    #1;
    model_out();
    check("an",   32'(an),           32'(e_an));
    check("seg",  32'(seg),          32'(e_seg));
    check("dp",   32'(dp),           32'(e_dp));
    check("fdone", 32'(frame_done),  32'(m_fd));
    check("lpend", 32'(load_pending), 32'(m_pv));
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
  endtask

  task automatic idle();
    drive(1'b0, 16'h0, 4'h0, 1'b0);
    tick();
  endtask

  task automatic check_dark(input string tag);
    check({tag, "_an"},  32'(an),           32'h0);
    check({tag, "_seg"}, 32'(seg),          32'h0);
    check({tag, "_dp"},  32'(dp),           32'h0);
    check({tag, "_fd"},  32'(frame_done),   32'h0);
    check({tag, "_lp"},  32'(load_pending), 32'h0);
  endtask

  // Hold reset across an edge and release it just after the next edge.
  task automatic do_reset();
    load = 1'b0; blank = 1'b0; value = '0; dp_in = '0;
    reset = 1'b1;
    #1;
    check_dark("rst");
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    logic        blank_r;
    logic        lr;
    font_tab = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                 7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
    reset = 1'b1; load = 1'b0; blank = 1'b0; value = '0; dp_in = '0;
    model_reset();
    #12;
    do_reset();

    // Scan timing from reset.
    for (int c = 0; c < 40; c++) begin
      drive(1'b0, 16'h0, 4'h0, 1'b0);
      if (c == 1)  check("t1_guard_an", 32'(an), 32'h0);
      if (c == 2)  begin check("t1_an0", 32'(an), 32'h1); check("t1_seg0", 32'(seg), 32'h7E); end
      if (c == 10) check("t1_an1", 32'(an), 32'h2);
      if (c == 31) check("t1_fd31", 32'(frame_done), 32'h0);
      if (c == 32) check("t1_fd32", 32'(frame_done), 32'h1);
      if (c == 33) check("t1_fd33", 32'(frame_done), 32'h0);
      tick();
    end

    // Tear-free load.
    do_reset();
    for (int c = 0; c < 72; c++) begin
      drive(c == 3, 16'h12AF, 4'b0100, 1'b0);
      if (c == 4)  begin check("t2_lp", 32'(load_pending), 32'h1); check("t2_old", 32'(seg), 32'h7E); end
      if (c == 35) begin check("t2_d0", 32'(seg), 32'h47); check("t2_lp0", 32'(load_pending), 32'h0); end
      if (c == 43) check("t2_d1", 32'(seg), 32'h77);
      if (c == 51) begin check("t2_d2", 32'(seg), 32'h6D); check("t2_dp2", 32'(dp), 32'h1); end
      if (c == 59) check("t2_d3", 32'(seg), 32'h30);
      tick();
    end

    // Two loads, then a load exactly on the boundary edge.
    drive(1'b1, 16'h1111, 4'h0, 1'b0); tick();
    idle(); idle();
    drive(1'b1, 16'h2222, 4'h0, 1'b0); tick();
    for (int k = 0; k < 100 && m_t != FR - 1; k++) idle();
    drive(1'b1, 16'h3333, 4'h0, 1'b0); tick();
    drive(1'b0, 16'h0, 4'h0, 1'b0);
    check("t3_lp", 32'(load_pending), 32'h0);
    tick();
    for (int k = 0; k < 100 && m_t != 4; k++) idle();
    drive(1'b0, 16'h0, 4'h0, 1'b0);
    check("t3_seg", 32'(seg), 32'h79);
    tick();

    // Blank mid-slot of digit 2, load while blanked, release.
    for (int k = 0; k < 100 && m_t != 2 * P + 4; k++) idle();
    drive(1'b0, 16'h0, 4'h0, 1'b1);
    check("t4_an_blank", 32'(an), 32'h0);
    check("t4_seg_blank", 32'(seg), 32'h0);
    tick();
    drive(1'b1, 16'h00C0, 4'h0, 1'b1); tick();
    drive(1'b0, 16'h0, 4'h0, 1'b1); tick();
    for (int k = 0; k <= 10; k++) begin
      drive(1'b0, 16'h0, 4'h0, 1'b0);
      if (k < 2)   check("t4_guard", 32'(an), 32'h0);
      if (k == 2)  check("t4_an0", 32'(an), 32'h1);
      if (k == 10) begin check("t4_an1", 32'(an), 32'h2); check("t4_seg1", 32'(seg), 32'h4E); end
      tick();
    end

    // Asynchronous reset mid-frame.
    for (int k = 0; k < 100 && m_t != 13; k++) idle();
    drive(1'b0, 16'h0, 4'h0, 1'b0);
    #1;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 16'h0, 4'h0, 1'b0);
      if (k == 3) begin check("t5_an", 32'(an), 32'h1); check("t5_seg", 32'(seg), 32'h7E); end
      tick();
    end

    // Leading-zero behaviour.
    drive(1'b1, 16'h0050, 4'h0, 1'b0); tick();
    for (int k = 0; k < 100 && m_pv; k++) idle();
    for (int k = 0; k < FR; k++) begin
      drive(1'b0, 16'h0, 4'h0, 1'b0);
      if (m_t == 3)  check("t6_d0", 32'(seg), 32'h7E);
      if (m_t == 11) check("t6_d1", 32'(seg), 32'h5B);
`ifdef SEVENSEG_LZ_BLANK_EN
      if (m_t == 19) begin check("t6_d2", 32'(seg), 32'h0); check("t6_an2", 32'(an), 32'h4); end
      if (m_t == 27) begin check("t6_d3", 32'(seg), 32'h0); check("t6_an3", 32'(an), 32'h8); end
`else
      if (m_t == 19) check("t6_d2", 32'(seg), 32'h7E);
      if (m_t == 27) check("t6_d3", 32'(seg), 32'h7E);
`endif
      tick();
    end

    // Random loads, values and blank bursts.
    blank_r = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if (!blank_r && $urandom_range(0, 199) == 0) blank_r = 1'b1;
      else if (blank_r && $urandom_range(0, 5) == 0) blank_r = 1'b0;
      lr = ($urandom_range(0, 23) == 0);
      drive(lr, 16'($urandom), 4'($urandom), blank_r);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
